sparse_merge_ctrl: RTL and testbench

Sequencer for the parallel indices comparison datapath in the sparse matrix multiplier. Walks two sorted, strictly increasing index lists: row nonzeros of A and column nonzeros of B. Each list sits in its own synchronous-read index memory. On every step the block presents one index from each list to the comparator, pulses the write strobe on a match, and advances the list pointers merge-style until either list is exhausted. It reports the match count and a completion pulse.

---
 rtl/sparse_merge_ctrl.sv | 143 ++++++++++++++
 tb/tb_sparse_merge_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_merge_ctrl.sv
// Merge sequencer for the sparse-multiply index comparator: walks two sorted
// index lists held in synchronous-read memories and strobes matches downstream.
module sparse_merge_ctrl #(
    parameter int unsigned IDX_W  = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   a_len,
    input  logic [ADDR_W:0]   b_len,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [IDX_W-1:0]  a_idx,
    input  logic [IDX_W-1:0]  b_idx,
    input  logic              fifo_full,
    output logic [IDX_W-1:0]  pic_A0,
    output logic [IDX_W-1:0]  pic_B0,
    output logic              pic_write,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   match_count
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   a_ptr_q;
    logic [PTR_W-1:0]   b_ptr_q;
    logic [PTR_W-1:0]   a_len_q;
    logic [PTR_W-1:0]   b_len_q;
    logic [PTR_W-1:0]   match_count_q;
    logic [ADDR_W-1:0]  a_addr_q;
    logic [ADDR_W-1:0]  b_addr_q;
    logic               busy_q;
    logic               done_q;

    logic               in_cmp_c;
    logic               eq_c;
    logic               lt_c;
    logic               accept_c;
    logic               adv_a_c;
    logic               adv_b_c;
    logic [PTR_W-1:0]   a_ptr_nx_c;
    logic [PTR_W-1:0]   b_ptr_nx_c;
    logic               end_c;

    // Compare/advance decision; the comparator path sees memory data directly in CMP.
    always_comb begin
        in_cmp_c   = (state_q == CMP);
        eq_c       = (a_idx == b_idx);
        lt_c       = (a_idx < b_idx);
        accept_c   = in_cmp_c && eq_c && !fifo_full;
        adv_a_c    = accept_c || (in_cmp_c && lt_c);
        adv_b_c    = accept_c || (in_cmp_c && !eq_c && !lt_c);
        a_ptr_nx_c = a_ptr_q + PTR_W'(adv_a_c);
        b_ptr_nx_c = b_ptr_q + PTR_W'(adv_b_c);
        end_c      = (a_ptr_nx_c == a_len_q) || (b_ptr_nx_c == b_len_q);
    end

    // Addresses only move on entry to FETCH, so a stalled CMP keeps read data stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            a_ptr_q       <= '0;
            b_ptr_q       <= '0;
            a_len_q       <= '0;
            b_len_q       <= '0;
            match_count_q <= '0;
            a_addr_q      <= '0;
            b_addr_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_len_q       <= a_len;
                        b_len_q       <= b_len;
                        a_ptr_q       <= '0;
                        b_ptr_q       <= '0;
                        match_count_q <= '0;
                        if ((a_len == '0) || (b_len == '0)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= FETCH;
                            busy_q   <= 1'b1;
                            a_addr_q <= '0;
                            b_addr_q <= '0;
                        end
                    end
                end
                FETCH: begin
                    state_q <= CMP;
                end
                CMP: begin
                    if (adv_a_c || adv_b_c) begin
                        a_ptr_q <= a_ptr_nx_c;
                        b_ptr_q <= b_ptr_nx_c;
                        if (accept_c) begin
                            match_count_q <= match_count_q + PTR_W'(1);
                        end
                        if (end_c) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= FETCH;
                            a_addr_q <= a_ptr_nx_c[ADDR_W-1:0];
                            b_addr_q <= b_ptr_nx_c[ADDR_W-1:0];
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_addr      = a_addr_q;
    assign b_addr      = b_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign match_count = match_count_q;
    assign pic_A0      = in_cmp_c ? a_idx : '0;
    assign pic_B0      = in_cmp_c ? b_idx : '0;
    assign pic_write   = accept_c;

endmodule

// File: tb/tb_sparse_merge_ctrl.sv
// Directed bench for sparse_merge_ctrl: memory model, cycle-accurate done timing,
// captured comparator writes and backpressure/reset/start-ignore corner cases.
module tb_sparse_merge_ctrl;

    localparam int unsigned IDX_W  = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [PTR_W-1:0]  a_len = '0;
    logic [PTR_W-1:0]  b_len = '0;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [IDX_W-1:0]  a_idx = '0;
    logic [IDX_W-1:0]  b_idx = '0;
    logic              fifo_full = 1'b0;
    logic [IDX_W-1:0]  pic_A0;
    logic [IDX_W-1:0]  pic_B0;
    logic              pic_write;
    logic              busy;
    logic              done;
    logic [PTR_W-1:0]  match_count;

    logic [IDX_W-1:0]  a_mem [256];
    logic [IDX_W-1:0]  b_mem [256];
    logic [31:0]       wr_q [$];
    logic [ADDR_W-1:0] a_hist [16];
    logic [ADDR_W-1:0] b_hist [16];

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;

    sparse_merge_ctrl #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_len       (a_len),
        .b_len       (b_len),
        .a_addr      (a_addr),
        .b_addr      (b_addr),
        .a_idx       (a_idx),
        .b_idx       (b_idx),
        .fifo_full   (fifo_full),
        .pic_A0      (pic_A0),
        .pic_B0      (pic_B0),
        .pic_write   (pic_write),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read index memories
    always @(posedge clk) begin
        a_idx <= a_mem[a_addr];
        b_idx <= b_mem[b_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = '1;
            b_mem[i] = '1;
        end
    endtask

    task automatic load_basic();
        clear_mems();
        a_mem[0] = 16'd1; a_mem[1] = 16'd4; a_mem[2] = 16'd7; a_mem[3] = 16'd9;
        b_mem[0] = 16'd2; b_mem[1] = 16'd4; b_mem[2] = 16'd9; b_mem[3] = 16'd12;
    endtask

    // Cycle 0 is the cycle start is driven; cycle c is the c-th cycle after it.
    task automatic run_merge(input int al, input int bl, input int stall_until,
                             input int restart_cyc, output int done_cyc, output int busy_cnt);
        int cyc;
        wr_q.delete();
        done_cyc = 0;
        busy_cnt = 0;
        @(negedge clk);
        a_len = PTR_W'(al);
        b_len = PTR_W'(bl);
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (cyc < 2000) begin
            start     = (cyc == restart_cyc);
            fifo_full = (cyc <= stall_until);
            #1;
            if (cyc < 16) begin
                a_hist[cyc] = a_addr;
                b_hist[cyc] = b_addr;
            end
            if (pic_write) begin
                wr_q.push_back({pic_A0, pic_B0});
                if (fifo_full) viol++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        start     = 1'b0;
        fifo_full = 1'b0;
    endtask

    initial begin
        int dc;
        int bc;

        clear_mems();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_a_addr", 32'(a_addr), 0);
        check_eq("rst_pic_A0", 32'(pic_A0), 0);
        check_eq("rst_pic_write", 32'(pic_write), 0);
        check_eq("rst_match_count", 32'(match_count), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic merge
        load_basic();
        run_merge(4, 4, 0, 0, dc, bc);
        check_eq("basic_done_cycle", dc, 11);
        check_eq("basic_busy_cycles", bc, 10);
        check_eq("basic_writes", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check_eq("basic_wr0", wr_q[0], {16'd4, 16'd4});
            check_eq("basic_wr1", wr_q[1], {16'd9, 16'd9});
        end
        check_eq("basic_match_count", 32'(match_count), 2);

        // Empty list: no activity, addresses keep the previous merge's final values
        run_merge(0, 3, 0, 0, dc, bc);
        check_eq("empty_done_cycle", dc, 1);
        check_eq("empty_busy_cycles", bc, 0);
        check_eq("empty_writes", wr_q.size(), 0);
        check_eq("empty_a_addr_hist", 32'(a_hist[1]), 3);
        check_eq("empty_b_addr_hist", 32'(b_hist[1]), 2);
        check_eq("empty_match_count", 32'(match_count), 0);

        // Disjoint lists
        clear_mems();
        a_mem[0] = 16'd1; a_mem[1] = 16'd3;
        b_mem[0] = 16'd2; b_mem[1] = 16'd4;
        run_merge(2, 2, 0, 0, dc, bc);
        check_eq("disjoint_done_cycle", dc, 7);
        check_eq("disjoint_writes", wr_q.size(), 0);
        check_eq("disjoint_match_count", 32'(match_count), 0);

        // Backpressure on the matching step (CMP cycles 4..6 stalled)
        clear_mems();
        a_mem[0] = 16'd1; a_mem[1] = 16'd5;
        b_mem[0] = 16'd5;
        run_merge(2, 1, 6, 0, dc, bc);
        check_eq("bp_done_cycle", dc, 8);
        check_eq("bp_busy_cycles", bc, 7);
        check_eq("bp_writes", wr_q.size(), 1);
        if (wr_q.size() == 1) check_eq("bp_wr0", wr_q[0], {16'd5, 16'd5});
        for (int c = 3; c <= 7; c++) begin
            check_eq($sformatf("bp_a_addr_c%0d", c), 32'(a_hist[c]), 1);
            check_eq($sformatf("bp_b_addr_c%0d", c), 32'(b_hist[c]), 0);
        end
        check_eq("bp_match_count", 32'(match_count), 1);

        // Start during a merge is ignored
        load_basic();
        run_merge(4, 4, 0, 3, dc, bc);
        check_eq("restart_busy_done_cycle", dc, 11);
        check_eq("restart_busy_match_count", 32'(match_count), 2);

        // Start during the DONE cycle is ignored
        run_merge(4, 4, 0, 11, dc, bc);
        check_eq("restart_done_done_cycle", dc, 11);
        #1;
        check_eq("restart_done_busy_after", 32'(busy), 0);
        check_eq("restart_done_match_count", 32'(match_count), 2);

        // Asynchronous reset during the first matching CMP (cycle 6)
        load_basic();
        @(negedge clk);
        a_len = PTR_W'(4);
        b_len = PTR_W'(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 6; c++) @(negedge clk);
        #1;
        check_eq("midrst_pre_write", 32'(pic_write), 1);
        check_eq("midrst_pre_a_addr", 32'(a_addr), 1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_pic_write", 32'(pic_write), 0);
        check_eq("midrst_pic_A0", 32'(pic_A0), 0);
        check_eq("midrst_pic_B0", 32'(pic_B0), 0);
        check_eq("midrst_a_addr", 32'(a_addr), 0);
        check_eq("midrst_b_addr", 32'(b_addr), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        run_merge(4, 4, 0, 0, dc, bc);
        check_eq("postrst_done_cycle", dc, 11);
        check_eq("postrst_match_count", 32'(match_count), 2);

        // Full-length identical lists 0..255
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = 16'(i);
            b_mem[i] = 16'(i);
        end
        run_merge(256, 256, 0, 0, dc, bc);
        check_eq("full_done_cycle", dc, 513);
        check_eq("full_writes", wr_q.size(), 256);
        if (wr_q.size() == 256) check_eq("full_last_wr", wr_q[255], {16'd255, 16'd255});
        check_eq("full_match_count", 32'(match_count), 256);

        check_eq("no_write_while_full", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
